// File: rtl/amiq_dvcon_blue_pkg.sv
// amiq_dvcon_blue_pkg: shared types and constants for the blue serializer
package amiq_dvcon_blue_pkg;

   localparam int DROP_CNT_W = 16;

   // field0 occupies the most significant word so {field0,field1,field2} packs directly
   typedef struct packed {
      logic [31:0] field0;
      logic [31:0] field1;
      logic [31:0] field2;
   } blue_item_t;

   typedef enum logic [1:0] {
      B0 = 2'd0,
      B1 = 2'd1,
      B2 = 2'd2
   } beat_e;

   // successor beat, B2 wraps back to B0
   function automatic beat_e next_beat(input beat_e b);
      return (b == B0) ? B1 : (b == B1) ? B2 : B0;
   endfunction

endpackage

// File: rtl/amiq_dvcon_blue_fifo.sv
// amiq_dvcon_blue_fifo: circular buffer of blue transactions with first-word-fall-through head
module amiq_dvcon_blue_fifo
   import amiq_dvcon_blue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  blue_item_t               din,
   output logic                     full,
   output logic                     empty,
   output blue_item_t               head,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   blue_item_t    r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [LW-1:0] r_level;
   logic          w_wr;
   logic          w_rd;

   // a full buffer still accepts a push when the head leaves in the same cycle
   assign w_rd  = pop & ~empty;
   assign w_wr  = push & (~full | w_rd);
   assign full  = r_level == LW'(DEPTH);
   assign empty = r_level == '0;
   assign head  = r_mem[r_rd];
   assign level = r_level;

   // storage array, contents are don't-care until written
   always_ff @(posedge clk) begin
      if (w_wr && !rst) r_mem[r_wr] <= din;
   end

   // pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_wr) r_wr <= r_wr + 1'b1;
         if (w_rd) r_rd <= r_rd + 1'b1;
         r_level <= r_level + LW'(w_wr) - LW'(w_rd);
      end
   end

endmodule

// File: rtl/amiq_dvcon_blue_serializer.sv
// amiq_dvcon_blue_serializer: buffers 3-word blue transactions and emits them as 32-bit beats
module amiq_dvcon_blue_serializer
   import amiq_dvcon_blue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             field0,
   input  logic [31:0]             field1,
   input  logic [31:0]             field2,
   input  logic                    valid,
   output logic [31:0]             out_data,
   output logic                    out_valid,
   output logic                    out_last,
   input  logic                    out_ready,
   output logic [$clog2(DEPTH):0]  level,
   output logic [DROP_CNT_W-1:0]   drop_cnt
);

   beat_e                 r_beat;
   logic [DROP_CNT_W-1:0] r_drop_cnt;
   blue_item_t            w_head;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_hs;
   logic                  w_pop;
   logic                  w_drop;

   amiq_dvcon_blue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (valid),
      .pop   (w_pop),
      .din   ('{field0: field0, field1: field1, field2: field2}),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head),
      .level (level)
   );

   assign w_hs      = out_valid & out_ready;
   assign w_pop     = w_hs & (r_beat == B2);
   assign w_drop    = valid & w_full & ~w_pop;
   assign out_valid = ~w_empty;
   assign out_last  = ~w_empty & (r_beat == B2);
   assign drop_cnt  = r_drop_cnt;

   // beat select from the head entry, forced to zero while nothing is buffered
   always_comb begin
      out_data = w_empty ? '0 :
                 (r_beat == B0) ? w_head.field0 :
                 (r_beat == B1) ? w_head.field1 : w_head.field2;
   end

   // beat FSM advances only on an accepted beat
   always_ff @(posedge clk) begin
      if (rst) r_beat <= B0;
      else if (w_hs) r_beat <= next_beat(r_beat);
   end

   // saturating count of transactions lost to a full buffer
   always_ff @(posedge clk) begin
      if (rst) r_drop_cnt <= '0;
      else if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
   end

endmodule

// File: tb/tb_amiq_dvcon_blue_serializer.sv
// tb_amiq_dvcon_blue_serializer: scoreboard bench for the blue serializer
module tb_amiq_dvcon_blue_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] field0 = '0;
   logic [31:0] field1 = '0;
   logic [31:0] field2 = '0;
   logic        valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_last;
   logic [2:0]  level;
   logic [15:0] drop_cnt;

   int n_checks = 0;
   int n_fail = 0;
   logic [32:0] exp_q [$];

   amiq_dvcon_blue_serializer #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .field0    (field0),
      .field1    (field1),
      .field2    (field2),
      .valid     (valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .level     (level),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // drive one transaction for the coming edge; optionally expect all three beats
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input bit expect_it);
      field0 = a;
      field1 = b;
      field2 = c;
      valid  = 1'b1;
      if (expect_it) begin
         exp_q.push_back({a, 1'b0});
         exp_q.push_back({b, 1'b0});
         exp_q.push_back({c, 1'b1});
      end
   endtask

   // monitor: every accepted beat must match the oldest expected beat
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", out_data, 32'hDEAD_BEEF);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("beat_data", out_data, e[32:1]);
            check("beat_last", 32'(out_last), 32'(e[0]));
         end
      end
   end

   initial begin
      // reset state
      cyc();
      cyc();
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_out_data", out_data, 0);
      check("rst_level", 32'(level), 0);
      check("rst_drop_cnt", 32'(drop_cnt), 0);

      // single transaction, first beat one cycle after the push
      out_ready = 1'b1;
      send(32'h11, 32'h22, 32'h33, 1);
      cyc();
      valid = 1'b0;
      check("lat_out_valid", 32'(out_valid), 1);
      check("lat_out_data", out_data, 32'h11);
      check("lat_level", 32'(level), 1);
      repeat (3) cyc();
      check("single_level", 32'(level), 0);
      check("single_out_valid", 32'(out_valid), 0);

      // backpressure held in B1 for five cycles
      send(32'hA1, 32'hA2, 32'hA3, 1);
      cyc();
      valid = 1'b0;
      cyc();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("bp_data", out_data, 32'hA2);
         check("bp_valid", 32'(out_valid), 1);
         check("bp_last", 32'(out_last), 0);
      end
      out_ready = 1'b1;
      repeat (2) cyc();
      check("bp_level", 32'(level), 0);

      // overflow: six back-to-back transactions with no drain
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send(32'h100 + 32'(i * 16), 32'h101 + 32'(i * 16), 32'h102 + 32'(i * 16), i < 4);
         cyc();
      end
      valid = 1'b0;
      check("ovf_level", 32'(level), 4);
      check("ovf_drop_cnt", 32'(drop_cnt), 2);

      // push while full during the B2 handshake
      out_ready = 1'b1;
      repeat (2) cyc();
      check("fp_last_before", 32'(out_last), 1);
      send(32'hB1, 32'hB2, 32'hB3, 1);
      cyc();
      valid = 1'b0;
      check("fp_level", 32'(level), 4);
      check("fp_drop_cnt", 32'(drop_cnt), 2);
      check("fp_next_head", out_data, 32'h110);
      for (int i = 0; i < 20 && level != 0; i++) cyc();
      check("fp_drained", 32'(level), 0);

      // reset while in B1 with three entries buffered
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(32'hC0 + 32'(i), 32'hD0 + 32'(i), 32'hE0 + 32'(i), 0);
         cyc();
      end
      valid = 1'b0;
      out_ready = 1'b1;
      exp_q.push_back({32'hC0, 1'b0});
      cyc();
      out_ready = 1'b0;
      check("rmo_level", 32'(level), 3);
      check("rmo_b1_data", out_data, 32'hD0);
      rst = 1'b1;
      send(32'hF0, 32'hF1, 32'hF2, 0);
      cyc();
      rst = 1'b0;
      valid = 1'b0;
      check("rmo_out_valid", 32'(out_valid), 0);
      check("rmo_level0", 32'(level), 0);
      check("rmo_drop_cnt", 32'(drop_cnt), 0);
      out_ready = 1'b1;
      send(32'h55, 32'h66, 32'h77, 1);
      cyc();
      valid = 1'b0;
      check("rmo_restart_b0", out_data, 32'h55);
      check("rmo_restart_last", 32'(out_last), 0);
      repeat (3) cyc();
      check("rmo_restart_done", 32'(level), 0);

      // saturation: fill four, then 65540 drops
      out_ready = 1'b0;
      send(32'h1, 32'h2, 32'h3, 0);
      repeat (4 + 65540) cyc();
      valid = 1'b0;
      check("sat_drop_cnt", 32'(drop_cnt), 32'hFFFF);
      check("sat_level", 32'(level), 4);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("sat_rst_drop_cnt", 32'(drop_cnt), 0);

      cyc();
      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
